// File: rtl/ame_pkg.sv
// Shared definitions for the AME numeric divider: default width, FSM states
// and saturation constants.
package ame_pkg;

  localparam int COMP_DATA_BITS_DEF = 64;
  localparam int SAT_MAX_BITS       = 128;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  typedef struct packed {
    logic [SAT_MAX_BITS-1:0] pos;
    logic [SAT_MAX_BITS-1:0] neg;
  } sat_t;

  // Positive (2^(n-1)-1) and negative (-2^(n-1), as an n-bit pattern) limits.
  function automatic sat_t sat_max(input int n);
    sat_t s;
    s.pos = '0;
    s.neg = '0;
    for (int i = 0; i < SAT_MAX_BITS; i++) begin
      if (i < n - 1) s.pos[i] = 1'b1;
      if (i == n - 1) s.neg[i] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/ame_div_lane.sv
// One unsigned radix-2 restoring divider datapath; sequencing comes from the
// parent through load/step.
module ame_div_lane
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = COMP_DATA_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      load,
  input  logic                      step,
  input  logic [COMP_DATA_BITS-1:0] dividend,
  input  logic [COMP_DATA_BITS-1:0] divisor,
  output logic [COMP_DATA_BITS-1:0] quot
);

  localparam int N = COMP_DATA_BITS;

  logic [N-1:0] rem_p0;
  logic [N-1:0] quo_p0;
  logic [N-1:0] dvs_p0;
  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         qbit;
  logic [N-1:0] rem_nxt;

  // quo_p0 starts as the dividend; its MSBs feed the remainder while
  // quotient bits fill in from the bottom.
  always_comb begin
    shifted = {rem_p0, quo_p0[N-1]};
    diff    = shifted - {1'b0, dvs_p0};
    qbit    = (shifted >= {1'b0, dvs_p0});
    rem_nxt = qbit ? diff[N-1:0] : shifted[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
      dvs_p0 <= divisor;
    end else if (step) begin
      rem_p0 <= rem_nxt;
      quo_p0 <= {quo_p0[N-2:0], qbit};
    end
  end

  assign quot = quo_p0;

endmodule

// File: rtl/ame_num_div.sv
// Sequential signed divider: Q1 = M/D and Q0 = L/C in lock-step, truncated
// toward zero, with divide-by-zero and overflow saturation.
module ame_num_div
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = COMP_DATA_BITS_DEF,
  parameter int SHIFT_BITS     = $clog2(COMP_DATA_BITS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           comp_init_i,
  input  logic [SHIFT_BITS-1:0]          comp_shift_i,
  input  logic [3:0][COMP_DATA_BITS-1:0] comp_data_i,
  output logic                           comp_busy_o,
  output logic                           comp_done_o,
  output logic [SHIFT_BITS-1:0]          comp_shift_o,
  output logic [1:0][COMP_DATA_BITS-1:0] comp_quot_o
);

  localparam int           N        = COMP_DATA_BITS;
  localparam int           CW       = $clog2(N);
  localparam sat_t         SAT      = sat_max(N);
  localparam logic [N-1:0] POS_SAT  = SAT.pos[N-1:0];
  localparam logic [N-1:0] NEG_SAT  = SAT.neg[N-1:0];
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  function automatic logic [N-1:0] abs_mag(input logic signed [N-1:0] x);
    logic [N-1:0] u;
    u = x;
    return u[N-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [N-1:0] fix_quot(input logic [N-1:0] mag,
                                            input logic neg,
                                            input logic den_zero,
                                            input logic num_zero,
                                            input logic num_neg);
    if (den_zero) return num_zero ? '0 : (num_neg ? NEG_SAT : POS_SAT);
    if (neg) return ~mag + 1'b1;
    if (mag[N-1]) return POS_SAT;
    return mag;
  endfunction

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic [1:0]            q_neg;
  logic [1:0]            den_zero;
  logic [1:0]            num_zero;
  logic [1:0]            num_neg;
  logic [SHIFT_BITS-1:0] shift_cap;
  logic [1:0][N-1:0]     raw;
  logic [1:0][N-1:0]     fixed;

  assign accept = (state == IDLE) && comp_init_i;

  // Lane g divides comp_data_i[2g+1] by comp_data_i[2g].
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic signed [N-1:0] num;
    logic signed [N-1:0] den;
    assign num = comp_data_i[2*g+1];
    assign den = comp_data_i[2*g];

    ame_div_lane #(.COMP_DATA_BITS(N)) u_lane (
      .clk      (clk_i),
      .load     (accept),
      .step     (state == CALC),
      .dividend (abs_mag(num)),
      .divisor  (abs_mag(den)),
      .quot     (raw[g])
    );

    always_ff @(posedge clk_i) begin
      if (accept) begin
        q_neg[g]    <= num[N-1] ^ den[N-1];
        den_zero[g] <= (den == '0);
        num_zero[g] <= (num == '0);
        num_neg[g]  <= num[N-1];
      end
    end

    assign fixed[g] = fix_quot(raw[g], q_neg[g], den_zero[g], num_zero[g], num_neg[g]);
  end

  always_ff @(posedge clk_i) begin
    if (accept) shift_cap <= comp_shift_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      comp_busy_o  <= 1'b0;
      comp_done_o  <= 1'b0;
      comp_shift_o <= '0;
      comp_quot_o  <= '0;
    end else begin
      comp_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (comp_init_i) begin
            state       <= CALC;
            cnt         <= CNT_LAST;
            comp_busy_o <= 1'b1;
          end
        end
        CALC: begin
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 1'b1;
        end
        FIX: begin
          comp_quot_o  <= fixed;
          comp_shift_o <= shift_cap;
          comp_done_o  <= 1'b1;
          comp_busy_o  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ame_num_div.sv
// Scoreboard bench for ame_num_div: expected quotients queued at issue time,
// popped and compared when done pulses.
module tb_ame_num_div;

  localparam int N   = 64;
  localparam int SB  = 6;
  localparam int LAT = N + 2;
  localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;
  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init = 1'b0;
  logic [SB-1:0]     shift_in = '0;
  logic [3:0][63:0]  data = '0;
  logic              busy;
  logic              done;
  logic [SB-1:0]     shift_out;
  logic [1:0][63:0]  quot;

  typedef struct {
    logic [63:0]   q1;
    logic [63:0]   q0;
    logic [SB-1:0] sh;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ame_num_div #(.COMP_DATA_BITS(N), .SHIFT_BITS(SB)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .comp_init_i  (init),
    .comp_shift_i (shift_in),
    .comp_data_i  (data),
    .comp_busy_o  (busy),
    .comp_done_o  (done),
    .comp_shift_o (shift_out),
    .comp_quot_o  (quot)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic signed [63:0] n, input logic signed [63:0] d);
    if (d == 0) return (n == 0) ? 64'd0 : ((n < 0) ? MINV : MAXV);
    if (n == MINV && d == -64'sd1) return MAXV;
    return n / d;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < 4; i++) data[i] = rnd64();
    shift_in = SB'($urandom);
  endtask

  // Drives one init cycle (caller sits just after an edge); returns just after E0.
  task automatic issue(input logic signed [63:0] m, input logic signed [63:0] d,
                       input logic signed [63:0] l, input logic signed [63:0] c,
                       input logic [SB-1:0] sh);
    exp_t e;
    data[3] = m; data[2] = d; data[1] = l; data[0] = c;
    shift_in = sh;
    init = 1'b1;
    e.q1 = model(m, d);
    e.q0 = model(l, c);
    e.sh = sh;
    exp_q.push_back(e);
    @(posedge clk); #1;
    init = 1'b0;
    scramble_inputs();
  endtask

  // lat counts edges from E0 inclusive until done is seen (bounded).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = busy;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_case(input string name,
                          input logic signed [63:0] m, input logic signed [63:0] d,
                          input logic signed [63:0] l, input logic signed [63:0] c,
                          input logic [SB-1:0] sh);
    exp_t e;
    int   lat;
    bit   bok;
    issue(m, d, l, c, sh);
    wait_done(lat, bok);
    e = exp_q.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, LAT); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL %s busy_in_flight got=%0b exp=1", name, bok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%0b exp=0", name, busy); end
    total++; if (quot[1] !== e.q1) begin bad++; $display("FAIL %s q1 got=%0d exp=%0d", name, $signed(quot[1]), $signed(e.q1)); end
    total++; if (quot[0] !== e.q0) begin bad++; $display("FAIL %s q0 got=%0d exp=%0d", name, $signed(quot[0]), $signed(e.q0)); end
    total++; if (shift_out !== e.sh) begin bad++; $display("FAIL %s shift got=%0d exp=%0d", name, shift_out, e.sh); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse_width got=%0b exp=0", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%0b exp=0", done); end
    total++; if (shift_out !== '0) begin bad++; $display("FAIL reset shift got=%0d exp=0", shift_out); end
    total++; if (quot !== '0) begin bad++; $display("FAIL reset quot got=%h exp=0", quot); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_case("basic", 100, 7, -100, 7, 5);
  endtask

  task automatic test_signs();
    run_case("signs", -7, -2, 7, -2, 1);
    run_case("zero_num", 0, 5, 1, MAXV, 2);
    for (int i = 0; i < 4; i++) begin
      logic signed [63:0] m, d, l, c;
      m = rnd64();
      d = (i[0]) ? 64'(signed'($urandom)) : rnd64();
      l = rnd64() >>> (i * 8);
      c = 64'(signed'($urandom_range(1, 1000))) * ((i < 2) ? -64'sd1 : 64'sd1);
      run_case("random", m, d, l, c, SB'(i + 10));
    end
  endtask

  task automatic test_div_zero();
    run_case("div_zero", 42, 0, -42, 0, 7);
    run_case("zero_zero", 0, 0, -1, 0, 8);
  endtask

  task automatic test_overflow();
    run_case("overflow", MINV, -1, MINV, 1, 63);
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   lat;
    int   extra;
    issue(1000, 3, -999, 10, 3);
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 5 || lat == 40 || lat == LAT - 1) begin
        init = 1'b1;
        scramble_inputs();
      end else begin
        init = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    init = 1'b0;
    e = exp_q.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL busy_ignore latency got=%0d exp=%0d", lat, LAT); end
    total++; if (quot[1] !== e.q1) begin bad++; $display("FAIL busy_ignore q1 got=%0d exp=%0d", $signed(quot[1]), $signed(e.q1)); end
    total++; if (quot[0] !== e.q0) begin bad++; $display("FAIL busy_ignore q0 got=%0d exp=%0d", $signed(quot[0]), $signed(e.q0)); end
    extra = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_ignore extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   bok;
    int   dones;
    issue(-123456789, 1000, 77, -7, 12);
    wait_done(lat, bok);
    e = exp_q.pop_front();
    total++; if (quot[1] !== e.q1) begin bad++; $display("FAIL b2b_first q1 got=%0d exp=%0d", $signed(quot[1]), $signed(e.q1)); end
    total++; if (quot[0] !== e.q0) begin bad++; $display("FAIL b2b_first q0 got=%0d exp=%0d", $signed(quot[0]), $signed(e.q0)); end
    issue(555, -5, MAXV, 2, 33);
    wait_done(lat, bok);
    e = exp_q.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_second latency got=%0d exp=%0d", lat, LAT); end
    total++; if (quot[1] !== e.q1) begin bad++; $display("FAIL b2b_second q1 got=%0d exp=%0d", $signed(quot[1]), $signed(e.q1)); end
    total++; if (quot[0] !== e.q0) begin bad++; $display("FAIL b2b_second q0 got=%0d exp=%0d", $signed(quot[0]), $signed(e.q0)); end
    total++; if (shift_out !== e.sh) begin bad++; $display("FAIL b2b_second shift got=%0d exp=%0d", shift_out, e.sh); end
    // Results must hold while idle.
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL hold done_count got=%0d exp=0", dones); end
    total++; if (quot[1] !== e.q1 || quot[0] !== e.q0) begin bad++; $display("FAIL hold quot got=%h exp=%h_%h", quot, e.q1, e.q0); end
    total++; if (shift_out !== e.sh) begin bad++; $display("FAIL hold shift got=%0d exp=%0d", shift_out, e.sh); end
  endtask

  task automatic test_mid_reset();
    int dones;
    exp_t e;
    issue(900, 9, 800, 8, 21);
    repeat (29) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_reset done got=%0b exp=0", done); end
    total++; if (quot !== '0) begin bad++; $display("FAIL mid_reset quot got=%h exp=0", quot); end
    total++; if (shift_out !== '0) begin bad++; $display("FAIL mid_reset shift got=%0d exp=0", shift_out); end
    e = exp_q.pop_back();
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL mid_reset stray_done got=%0d exp=0", dones); end
    run_case("after_reset", -4000, 16, 31, -31, 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
